// File: rtl/exec_pkg.sv
// Shared constants for the execute-stage logic unit: default operand width and op codes.
// The issue logic and the decoder both import these.
package exec_pkg;

   localparam int unsigned W_OPR = 32;
   localparam int unsigned W_OP  = 3;

   // Codes 000-011 keep the older 2-bit select ordering.
   typedef enum logic [W_OP-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_NOT  = 3'b010,
      OP_XOR  = 3'b011,
      OP_NAND = 3'b100,
      OP_NOR  = 3'b101,
      OP_XNOR = 3'b110,
      OP_ANDN = 3'b111
   } op_e;

endpackage

// File: rtl/exec_logic_stage.sv
// One register stage of the logic pipe: valid bit, opaque payload, load decision and flush.
module exec_logic_stage #(
   parameter int unsigned W_PAY = 38
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             prev_valid_i,
   input  logic [W_PAY-1:0] prev_payload_i,
   input  logic             next_load_i,
   output logic             load_o,
   output logic             valid_o,
   output logic [W_PAY-1:0] payload_o
);

   logic             valid_q;
   logic [W_PAY-1:0] payload_q;

   // Loading while empty lets bubbles collapse under backpressure.
   assign load_o    = !valid_q || next_load_i;
   assign valid_o   = valid_q;
   assign payload_o = payload_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         if (flush_i) begin
            valid_q <= 1'b0;
         end else if (load_o) begin
            valid_q <= prev_valid_i;
         end
         // Payload only moves with a real item, so a stalled output stays put.
         if (load_o && prev_valid_i) begin
            payload_q <= prev_payload_i;
         end
      end
   end

endmodule

// File: rtl/exec_logic_pipe.sv
// Pipelined bitwise logic unit: decodes one of eight ops, then carries {result, zero, tag}
// through STAGES valid/ready register stages.
module exec_logic_pipe #(
   parameter int unsigned W_OPR  = exec_pkg::W_OPR,
   parameter int unsigned W_TAG  = 5,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [W_OPR-1:0] opr0_i,
   input  logic [W_OPR-1:0] opr1_i,
   input  logic [2:0]       op_i,
   input  logic [W_TAG-1:0] tag_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [W_OPR-1:0] result_o,
   output logic [W_TAG-1:0] tag_o,
   output logic             zero_o
);

   import exec_pkg::*;

   localparam int unsigned W_PAY = W_OPR + 1 + W_TAG;

   logic [W_OPR-1:0] res;
   logic [W_PAY-1:0] in_pay;

   always_comb begin
      res = '0;
      unique case (op_e'(op_i))
         OP_AND:  res = opr0_i & opr1_i;
         OP_OR:   res = opr0_i | opr1_i;
         OP_NOT:  res = ~opr0_i;
         OP_XOR:  res = opr0_i ^ opr1_i;
         OP_NAND: res = ~(opr0_i & opr1_i);
         OP_NOR:  res = ~(opr0_i | opr1_i);
         OP_XNOR: res = ~(opr0_i ^ opr1_i);
         OP_ANDN: res = opr0_i & ~opr1_i;
      endcase
   end

   assign in_pay = {res, (res == '0), tag_i};

   // Ready ripples back combinationally from out_ready_i through each stage's load.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             load;
      logic             valid;
      logic             prev_valid;
      logic             next_load;
      logic [W_PAY-1:0] prev_pay;
      logic [W_PAY-1:0] pay;

      if (k == 0) begin : g_first
         assign prev_valid = in_valid_i;
         assign prev_pay   = in_pay;
      end else begin : g_mid
         assign prev_valid = g_stage[k-1].valid;
         assign prev_pay   = g_stage[k-1].pay;
      end

      if (k == STAGES - 1) begin : g_last
         assign next_load = out_ready_i;
      end else begin : g_inner
         assign next_load = g_stage[k+1].load;
      end

      exec_logic_stage #(
         .W_PAY(W_PAY)
      ) u_stage (
         .clk_i         (clk_i),
         .rst_n_i       (rst_n_i),
         .flush_i       (flush_i),
         .prev_valid_i  (prev_valid),
         .prev_payload_i(prev_pay),
         .next_load_i   (next_load),
         .load_o        (load),
         .valid_o       (valid),
         .payload_o     (pay)
      );
   end

   assign in_ready_o  = g_stage[0].load;
   assign out_valid_o = g_stage[STAGES-1].valid;
   assign result_o    = g_stage[STAGES-1].pay[W_PAY-1 -: W_OPR];
   assign zero_o      = g_stage[STAGES-1].pay[W_TAG];
   assign tag_o       = g_stage[STAGES-1].pay[W_TAG-1:0];

endmodule

// File: tb/tb_exec_logic_pipe.sv
// Randomised bench for exec_logic_pipe over several width/depth configurations, each checked
// every cycle against an in-order queue model of the pipe.
module tb_exec_logic_pipe;

   localparam int NCFG = 6;

   function automatic int cfg_w(input int i);
      case (i)
         0, 1:    return 32;
         2:       return 1;
         3:       return 8;
         default: return 64;
      endcase
   endfunction

   function automatic int cfg_s(input int i);
      case (i)
         0:       return 2;
         1:       return 3;
         2:       return 1;
         3:       return 4;
         4:       return 1;
         default: return 4;
      endcase
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input int g, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL cfg%0d %s: got %0h expected %0h", g, nm, got, exp);
      end
   endtask

   // Hand-computed results for opr0=F0F0_1234, opr1=0FF0_FFFF.
   function automatic logic [31:0] lit(input logic [2:0] o);
      case (o)
         3'd0:    return 32'h00F0_1234;
         3'd1:    return 32'hFFF0_FFFF;
         3'd2:    return 32'h0F0F_EDCB;
         3'd3:    return 32'hFF00_EDCB;
         3'd4:    return 32'hFF0F_EDCB;
         3'd5:    return 32'h000F_0000;
         3'd6:    return 32'h00FF_1234;
         default: return 32'hF000_0000;
      endcase
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int W = cfg_w(g);
      localparam int S = cfg_s(g);

      logic         rst_n     = 1'b0;
      logic         in_valid  = 1'b0;
      logic         flush     = 1'b0;
      logic         out_ready = 1'b0;
      logic         rnd_ready = 1'b0;
      logic         use_lit   = 1'b0;
      logic         fin       = 1'b0;
      logic [W-1:0] opr0      = '0;
      logic [W-1:0] opr1      = '0;
      logic [W-1:0] lit_res   = '0;
      logic [2:0]   op        = '0;
      logic [4:0]   tag       = '0;
      logic         in_ready, out_valid, zero;
      logic [W-1:0] result;
      logic [4:0]   tag_out;

      logic [W-1:0] q_res[$];
      logic [4:0]   q_tag[$];
      int           q_edge[$];
      int           last_low = 0;

      exec_logic_pipe #(
         .W_OPR (W),
         .W_TAG (5),
         .STAGES(S)
      ) dut (
         .clk_i      (clk),
         .rst_n_i    (rst_n),
         .in_valid_i (in_valid),
         .in_ready_o (in_ready),
         .opr0_i     (opr0),
         .opr1_i     (opr1),
         .op_i       (op),
         .tag_i      (tag),
         .flush_i    (flush),
         .out_valid_o(out_valid),
         .out_ready_i(out_ready),
         .result_o   (result),
         .tag_o      (tag_out),
         .zero_o     (zero)
      );

      // Replicate a 32-bit pattern across W bits; bitwise ops commute with this.
      function automatic logic [W-1:0] fit(input logic [31:0] v);
         logic [W-1:0] r;
         for (int i = 0; i < W; i++) r[i] = v[i % 32];
         return r;
      endfunction

      function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] o);
         logic [W-1:0] base;
         case (o[1:0])
            2'd0:    base = a & b;
            2'd1:    base = a | b;
            2'd2:    base = ~a;
            default: base = a ^ b;
         endcase
         if (o == 3'd7) return a & ~b;
         if (o == 3'd6) return ~(a ^ b);
         if (o[2]) return ~base;
         return base;
      endfunction

      function automatic logic [W-1:0] rnd_w();
         logic [W-1:0] r;
         for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
         return r;
      endfunction

      // Occupancy model: queue of in-flight items, oldest at the output.
      initial forever begin
         @(negedge clk);
         if (!rst_n) begin
            q_res.delete();
            q_tag.delete();
            q_edge.delete();
         end else begin
            chk("in_ready", g, in_ready, !(q_res.size() == S && !out_ready));
            if (out_valid) begin
               chk("valid_has_item", g, q_res.size() > 0, 1);
               if (q_res.size() > 0) begin
                  chk("result", g, result, q_res[0]);
                  chk("tag", g, tag_out, q_tag[0]);
                  chk("zero", g, zero, q_res[0] == '0);
                  if (last_low < q_edge[0]) chk("latency", g, edges - q_edge[0] + 1, S);
               end
            end else if (q_res.size() > 0 && last_low < q_edge[0]) begin
               chk("not_late", g, (edges - q_edge[0] + 1) < S, 1);
            end
            if (!out_ready) last_low = edges + 1;
            if (out_valid && out_ready && q_res.size() > 0) begin
               void'(q_res.pop_front());
               void'(q_tag.pop_front());
               void'(q_edge.pop_front());
            end
            if (flush) begin
               q_res.delete();
               q_tag.delete();
               q_edge.delete();
            end else if (in_valid && in_ready) begin
               q_res.push_back(use_lit ? lit_res : ref_op(opr0, opr1, op));
               q_tag.push_back(tag);
               q_edge.push_back(edges + 1);
            end
         end
      end

      initial forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
      end

      task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                          input logic [4:0] t);
         logic acc;
         int   k;
         in_valid = 1'b1;
         opr0     = a;
         opr1     = b;
         op       = o;
         tag      = t;
         acc      = 1'b0;
         k        = 0;
         while (!acc && k < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
         end
         chk("accepted", g, acc, 1);
         in_valid = 1'b0;
      endtask

      task automatic send_rand(input logic [4:0] t);
         send(rnd_w(), rnd_w(), 3'($urandom_range(0, 7)), t);
      endtask

      initial begin
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk("rst_out_valid", g, out_valid, 0);
         chk("rst_result", g, result, 0);
         chk("rst_tag", g, tag_out, 0);
         chk("rst_zero", g, zero, 0);
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         #1;
         chk("rst_in_ready", g, in_ready, 1);

         // Op sweep and zero flag against literal expectations.
         out_ready = 1'b1;
         use_lit   = 1'b1;
         for (int o = 0; o < 8; o++) begin
            lit_res = fit(lit(3'(o)));
            chk("model_pin", g, ref_op(fit(32'hF0F0_1234), fit(32'h0FF0_FFFF), 3'(o)), lit_res);
            send(fit(32'hF0F0_1234), fit(32'h0FF0_FFFF), 3'(o), 5'(o + 8));
         end
         lit_res = '0;
         send(fit(32'hAAAA_AAAA), fit(32'h5555_5555), 3'd0, 5'd20);
         lit_res = '1;
         send(fit(32'h1234_5678), fit(32'h1234_5678), 3'd6, 5'd21);
         use_lit = 1'b0;
         repeat (S + 2) @(posedge clk);
         #1;

         // Full throughput.
         for (int i = 0; i < 20; i++) send_rand(5'(i));
         repeat (S + 2) @(posedge clk);
         #1;

         // Random backpressure with random input gaps.
         rnd_ready = 1'b1;
         for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 1)) begin
               @(posedge clk);
               #1;
            end
            send_rand(5'(i));
         end
         rnd_ready = 1'b0;
         out_ready = 1'b1;
         repeat (S + 4) @(posedge clk);
         #1;
         chk("bp_drained", g, q_res.size(), 0);

         // Flush with a full pipe, a concurrent consume and a concurrent input.
         out_ready = 1'b0;
         for (int i = 0; i < S; i++) send_rand(5'(i));
         out_ready = 1'b1;
         flush     = 1'b1;
         send_rand(5'd30);
         flush = 1'b0;
         @(negedge clk);
         chk("flush_out_valid", g, out_valid, 0);
         @(posedge clk);
         #1;
         send_rand(5'd31);
         repeat (S + 2) @(posedge clk);
         #1;
         chk("flush_drained", g, q_res.size(), 0);

         // Asynchronous reset in the middle of a cycle.
         out_ready = 1'b0;
         for (int i = 0; i < S; i++) send_rand(5'(i));
         #3;
         chk("pre_rst_valid", g, out_valid, 1);
         rst_n = 1'b0;
         #1;
         chk("async_rst_valid", g, out_valid, 0);
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         @(negedge clk);
         chk("post_rst_valid", g, out_valid, 0);
         @(posedge clk);
         #1;
         out_ready = 1'b1;
         for (int i = 0; i < 8; i++) send_rand(5'(i));
         repeat (S + 2) @(posedge clk);
         #1;
         chk("final_drained", g, q_res.size(), 0);
         fin = 1'b1;
      end
   end

   initial begin
      logic all_fin;
      int   k;
      k       = 0;
      all_fin = 1'b0;
      while (!all_fin && k < 20000) begin
         @(posedge clk);
         k++;
         all_fin = cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin && cfg[4].fin
                   && cfg[5].fin;
      end
      chk("all_configs_done", -1, all_fin, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
